// File: rtl/ddr4_iod_rx_lane_trainer.sv
// rtl/ddr4_iod_rx_lane_trainer.sv - DDR4 4:1 input IOD receive-lane eye trainer and word aligner
//
// Scans the IOD delay line from tap 0 upward, looking for the first window of
// taps where every sampled word is one fixed rotation of PATTERN. Once a window of
// at least MIN_EYE taps closes, the trainer steps back to the window centre and
// bit-slips the lane until PATTERN arrives unrotated.
//
// Ports:
//   FAB_CLK, RESET_N          fabric clock, synchronous active-low reset
//   TRAIN_START               one-cycle request, accepted in IDLE/DONE/ERROR
//   PATTERN                   expected training word (4 distinct rotations)
//   RX_DATA                   deserialized word from the IOD
//   DELAY_LINE_OUT_OF_RANGE   IOD delay-line limit flag
//   DELAY_LINE_MOVE/DIRECTION tap step pulse and direction (1 = increment)
//   DELAY_LINE_LOAD           pulse that loads tap 0
//   RX_BIT_SLIP               pulse that rotates the IOD word by one bit
//   RX_DATA_OUT               RX_DATA registered once
//   DATA_VALID, TRAIN_DONE, TRAIN_ERR  status levels
//   EYE_START, EYE_END, CENTER_TAP     training results

module ddr4_iod_rx_lane_trainer #(
    parameter int MAX_TAPS      = 128,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16,
    parameter int MIN_EYE       = 4,
    localparam int TAP_W        = $clog2(MAX_TAPS)
) (
    input  logic             FAB_CLK,
    input  logic             RESET_N,
    input  logic             TRAIN_START,
    input  logic [3:0]       PATTERN,
    input  logic [3:0]       RX_DATA,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    output logic             RX_BIT_SLIP,
    output logic [3:0]       RX_DATA_OUT,
    output logic             DATA_VALID,
    output logic             TRAIN_DONE,
    output logic             TRAIN_ERR,
    output logic [TAP_W-1:0] EYE_START,
    output logic [TAP_W-1:0] EYE_END,
    output logic [TAP_W-1:0] CENTER_TAP
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_STEP, S_BACKOFF, S_SLIP, S_DONE, S_ERROR
    } state_t;

    state_t           state;
    state_t           ret_state;
    logic [15:0]      cnt;
    logic [TAP_W-1:0] cur_tap;
    logic             win_open;
    logic             tap_ok;
    logic [1:0]       cand_r;
    logic [1:0]       lock_r;
    logic [1:0]       slip_cnt;

    function automatic logic [3:0] rot_left(input logic [3:0] p, input logic [1:0] r);
        case (r)
            2'd0:    rot_left = p;
            2'd1:    rot_left = {p[2:0], p[3]};
            2'd2:    rot_left = {p[1:0], p[3:2]};
            default: rot_left = {p[0], p[3:1]};
        endcase
    endfunction

    // Which rotation of PATTERN, if any, the current word is.
    logic       rx_match;
    logic [1:0] rx_rot;
    always_comb begin
        rx_match = 1'b0;
        rx_rot   = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!rx_match && RX_DATA == rot_left(PATTERN, 2'(r))) begin
                rx_match = 1'b1;
                rx_rot   = 2'(r);
            end
        end
    end

    // The first word of a tap fixes the candidate rotation; later words must
    // repeat it, and an open window additionally pins it to the locked one.
    logic       first_word;
    logic [1:0] ref_r;
    logic       word_ok;
    logic       tap_pass;
    always_comb begin
        first_word = (cnt == 16'd0);
        ref_r      = first_word ? rx_rot : cand_r;
        word_ok    = rx_match && (rx_rot == ref_r) && (!win_open || rx_rot == lock_r);
        tap_pass   = word_ok && (first_word || tap_ok);
    end

    logic [TAP_W:0]   eye_width;
    logic             wide_enough;
    logic [TAP_W-1:0] center_calc;
    logic             at_limit;
    always_comb begin
        eye_width   = {1'b0, EYE_END} - {1'b0, EYE_START} + (TAP_W+1)'(1);
        wide_enough = (eye_width >= (TAP_W+1)'(MIN_EYE));
        center_calc = EYE_START + ((EYE_END - EYE_START) >> 1);
        at_limit    = (cur_tap == TAP_W'(MAX_TAPS-1)) || DELAY_LINE_OUT_OF_RANGE;
    end

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            RX_DATA_OUT <= 4'd0;
        end else begin
            RX_DATA_OUT <= RX_DATA;
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            state                <= S_IDLE;
            ret_state            <= S_IDLE;
            cnt                  <= 16'd0;
            cur_tap              <= '0;
            win_open             <= 1'b0;
            tap_ok               <= 1'b0;
            cand_r               <= 2'd0;
            lock_r               <= 2'd0;
            slip_cnt             <= 2'd0;
            DELAY_LINE_MOVE      <= 1'b0;
            DELAY_LINE_DIRECTION <= 1'b0;
            DELAY_LINE_LOAD      <= 1'b0;
            RX_BIT_SLIP          <= 1'b0;
            DATA_VALID           <= 1'b0;
            TRAIN_DONE           <= 1'b0;
            TRAIN_ERR            <= 1'b0;
            EYE_START            <= '0;
            EYE_END              <= '0;
            CENTER_TAP           <= '0;
        end else begin
            DELAY_LINE_MOVE <= 1'b0;
            DELAY_LINE_LOAD <= 1'b0;
            RX_BIT_SLIP     <= 1'b0;

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (TRAIN_START) begin
                        TRAIN_DONE           <= 1'b0;
                        TRAIN_ERR            <= 1'b0;
                        DATA_VALID           <= 1'b0;
                        win_open             <= 1'b0;
                        cur_tap              <= '0;
                        slip_cnt             <= 2'd0;
                        cnt                  <= 16'd0;
                        // Scan direction is established long before the first MOVE.
                        DELAY_LINE_DIRECTION <= 1'b1;
                        state                <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    DELAY_LINE_LOAD <= 1'b1;
                    ret_state       <= S_SAMPLE;
                    cnt             <= 16'd0;
                    state           <= S_SETTLE;
                end

                // The pulse cycle counts as the first settle cycle.
                S_SETTLE: begin
                    if (cnt == 16'(SETTLE_CYCLES-1)) begin
                        cnt   <= 16'd0;
                        state <= ret_state;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                S_SAMPLE: begin
                    tap_ok <= tap_pass;
                    cand_r <= ref_r;
                    if (cnt == 16'(SAMPLE_CYCLES-1)) begin
                        cnt <= 16'd0;
                        if (tap_pass) begin
                            if (!win_open) begin
                                win_open  <= 1'b1;
                                EYE_START <= cur_tap;
                                lock_r    <= ref_r;
                            end
                            EYE_END <= cur_tap;
                            state   <= S_STEP;
                        end else if (win_open) begin
                            win_open <= 1'b0;
                            if (wide_enough) begin
                                CENTER_TAP           <= center_calc;
                                DELAY_LINE_DIRECTION <= 1'b0;
                                state                <= S_BACKOFF;
                            end else begin
                                state <= S_STEP;
                            end
                        end else begin
                            state <= S_STEP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                S_STEP: begin
                    if (at_limit) begin
                        win_open <= 1'b0;
                        if (win_open && wide_enough) begin
                            CENTER_TAP           <= center_calc;
                            DELAY_LINE_DIRECTION <= 1'b0;
                            state                <= S_BACKOFF;
                        end else begin
                            TRAIN_ERR  <= 1'b1;
                            DATA_VALID <= 1'b0;
                            state      <= S_ERROR;
                        end
                    end else begin
                        DELAY_LINE_MOVE <= 1'b1;
                        cur_tap         <= cur_tap + TAP_W'(1);
                        ret_state       <= S_SAMPLE;
                        state           <= S_SETTLE;
                    end
                end

                // Direction was dropped to decrement on the way in, a cycle ahead of the first MOVE.
                S_BACKOFF: begin
                    if (cur_tap > CENTER_TAP) begin
                        DELAY_LINE_MOVE <= 1'b1;
                        cur_tap         <= cur_tap - TAP_W'(1);
                        ret_state       <= S_BACKOFF;
                        state           <= S_SETTLE;
                    end else begin
                        state <= S_SLIP;
                    end
                end

                S_SLIP: begin
                    if (slip_cnt != lock_r) begin
                        RX_BIT_SLIP <= 1'b1;
                        slip_cnt    <= slip_cnt + 2'd1;
                        ret_state   <= S_SLIP;
                        state       <= S_SETTLE;
                    end else begin
                        TRAIN_DONE <= 1'b1;
                        DATA_VALID <= 1'b1;
                        state      <= S_DONE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_iod_rx_lane_trainer.sv
// tb/tb_ddr4_iod_rx_lane_trainer.sv - self-checking bench for ddr4_iod_rx_lane_trainer
module tb_ddr4_iod_rx_lane_trainer;

    localparam int SETTLE = 8;
    localparam int TAP_W  = 7;
    localparam int BOUND  = 6000;

    logic             fab_clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             train_start = 1'b0;
    logic [3:0]       pattern = 4'b0001;
    logic [3:0]       rx_data;
    logic             oor;
    logic             move, dir, load, slip, data_valid, train_done, train_err;
    logic [3:0]       rx_data_out;
    logic [TAP_W-1:0] eye_start, eye_end, center_tap;

    always #5 fab_clk = ~fab_clk;

    ddr4_iod_rx_lane_trainer dut (
        .FAB_CLK                 (fab_clk),
        .RESET_N                 (reset_n),
        .TRAIN_START             (train_start),
        .PATTERN                 (pattern),
        .RX_DATA                 (rx_data),
        .DELAY_LINE_OUT_OF_RANGE (oor),
        .DELAY_LINE_MOVE         (move),
        .DELAY_LINE_DIRECTION    (dir),
        .DELAY_LINE_LOAD         (load),
        .RX_BIT_SLIP             (slip),
        .RX_DATA_OUT             (rx_data_out),
        .DATA_VALID              (data_valid),
        .TRAIN_DONE              (train_done),
        .TRAIN_ERR               (train_err),
        .EYE_START               (eye_start),
        .EYE_END                 (eye_end),
        .CENTER_TAP              (center_tap)
    );

    // IOD model scenario
    int w1_lo = 1000, w1_hi = -1, w1_r = 0;
    int w2_lo = 1000, w2_hi = -1, w2_r = 0;
    int raw_adj = 0;
    int oor_tap = 1000;
    bit oor_fail = 1'b0;

    // IOD model state
    int         m_tap = 0;
    int         inc_cnt = 0, dec_cnt = 0, slip_total = 0, load_cnt = 0;
    int         pulse_viol = 0;
    int         cyc = 0;
    int         last_pulse = -100;
    logic       prev_dir = 1'b0;
    logic [3:0] prev_rx = 4'd0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string tag;
        int    es, ee, ct, inc, dec, slips;
        bit    done;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [3:0] rotl4(input logic [3:0] v, input int n);
        int         k;
        logic [3:0] r;
        k = ((n % 4) + 4) % 4;
        r = v;
        for (int i = 0; i < k; i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    // Passing taps deliver one fixed rotation (undone by slips); failing taps
    // alternate between two different rotations so no single rotation holds.
    always_comb begin
        bit pass;
        int r;
        pass = 1'b0;
        r    = 0;
        if (m_tap >= w1_lo && m_tap <= w1_hi) begin
            pass = 1'b1;
            r    = w1_r;
        end else if (m_tap >= w2_lo && m_tap <= w2_hi) begin
            pass = 1'b1;
            r    = w2_r;
        end
        if (oor_fail && m_tap >= oor_tap) pass = 1'b0;
        if (pass) rx_data = rotl4(pattern, r + raw_adj - slip_total);
        else      rx_data = rotl4(pattern, (cyc % 2) * 2);
    end

    assign oor = (m_tap >= oor_tap);

    always @(posedge fab_clk) begin
        int v;
        v = 0;
        cyc      <= cyc + 1;
        prev_dir <= dir;
        prev_rx  <= rx_data;
        if (load) begin
            m_tap    <= 0;
            load_cnt <= load_cnt + 1;
        end
        if (move) begin
            if (dir) begin
                m_tap   <= m_tap + 1;
                inc_cnt <= inc_cnt + 1;
            end else begin
                m_tap   <= m_tap - 1;
                dec_cnt <= dec_cnt + 1;
            end
            if (dir !== prev_dir) v++;
        end
        if (slip) slip_total <= slip_total + 1;
        if (int'(load) + int'(move) + int'(slip) > 1) v++;
        if (load || move || slip) begin
            if (cyc - last_pulse < SETTLE + 1) v++;
            last_pulse <= cyc;
        end
        pulse_viol <= pulse_viol + v;
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic pulse_start();
        @(negedge fab_clk);
        train_start = 1'b1;
        @(negedge fab_clk);
        train_start = 1'b0;
    endtask

    task automatic setup(input logic [3:0] pat, input int lo1, input int hi1, input int r1,
                         input int lo2, input int hi2, input int r2,
                         input int otap, input bit ofail);
        @(negedge fab_clk);
        pattern  = pat;
        w1_lo = lo1; w1_hi = hi1; w1_r = r1;
        w2_lo = lo2; w2_hi = hi2; w2_r = r2;
        oor_tap  = otap;
        oor_fail = ofail;
        raw_adj  = slip_total;
    endtask

    task automatic run(input string tag, input logic [3:0] pat,
                       input int lo1, input int hi1, input int r1,
                       input int lo2, input int hi2, input int r2,
                       input int otap, input bit ofail,
                       input bit done, input int es, input int ee, input int ct,
                       input int inc, input int dec, input int slips);
        exp_t e;
        int   b_inc, b_dec, b_slip, b_load, n;
        setup(pat, lo1, hi1, r1, lo2, hi2, r2, otap, ofail);
        b_inc = inc_cnt; b_dec = dec_cnt; b_slip = slip_total; b_load = load_cnt;
        e.tag = tag; e.es = es; e.ee = ee; e.ct = ct;
        e.inc = inc; e.dec = dec; e.slips = slips; e.done = done;
        exp_q.push_back(e);
        pulse_start();
        repeat (200) @(negedge fab_clk);
        check({tag, "_rx_out_latency"}, int'(rx_data_out), int'(prev_rx));
        // A request mid-scan must be ignored.
        pulse_start();
        n = 0;
        while (!(train_done || train_err) && n < BOUND) begin
            @(negedge fab_clk);
            n++;
        end
        e = exp_q.pop_front();
        check({e.tag, "_finished"}, int'(train_done || train_err), 1);
        check({e.tag, "_done"}, int'(train_done), int'(e.done));
        check({e.tag, "_err"}, int'(train_err), int'(!e.done));
        check({e.tag, "_valid"}, int'(data_valid), int'(e.done));
        check({e.tag, "_loads"}, load_cnt - b_load, 1);
        check({e.tag, "_inc_moves"}, inc_cnt - b_inc, e.inc);
        check({e.tag, "_dec_moves"}, dec_cnt - b_dec, e.dec);
        check({e.tag, "_slips"}, slip_total - b_slip, e.slips);
        if (e.done) begin
            check({e.tag, "_eye_start"}, int'(eye_start), e.es);
            check({e.tag, "_eye_end"}, int'(eye_end), e.ee);
            check({e.tag, "_center"}, int'(center_tap), e.ct);
            check({e.tag, "_final_tap"}, m_tap, e.ct);
            repeat (2) @(negedge fab_clk);
            check({e.tag, "_aligned_word"}, int'(rx_data_out), int'(pat));
        end else begin
            check({e.tag, "_final_tap"}, m_tap, 127);
        end
    endtask

    initial begin
        int n, b_sum;

        repeat (3) @(negedge fab_clk);
        check("reset_outputs",
              int'({move, dir, load, slip, rx_data_out, data_valid, train_done, train_err,
                    eye_start, eye_end, center_tap}), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge fab_clk);

        run("eye_20_39", 4'b0001, 20, 39, 1, 1000, -1, 0, 1000, 1'b0,
            1'b1, 20, 39, 29, 40, 11, 1);
        run("narrow_then_50_70", 4'b0001, 5, 6, 2, 50, 70, 3, 1000, 1'b0,
            1'b1, 50, 70, 60, 71, 11, 3);
        run("no_eye", 4'b0001, 1000, -1, 0, 1000, -1, 0, 1000, 1'b0,
            1'b0, 0, 0, 0, 127, 0, 0);
        run("eye_top_open", 4'b0111, 100, 127, 0, 1000, -1, 0, 1000, 1'b0,
            1'b1, 100, 127, 113, 127, 14, 0);
        run("oor_data_lost", 4'b0001, 80, 95, 2, 1000, -1, 0, 90, 1'b1,
            1'b1, 80, 89, 84, 90, 6, 2);
        run("oor_step_limit", 4'b0001, 80, 95, 1, 1000, -1, 0, 90, 1'b0,
            1'b1, 80, 90, 85, 90, 5, 1);
        run("min_eye_width", 4'b0001, 60, 63, 0, 1000, -1, 0, 1000, 1'b0,
            1'b1, 60, 63, 61, 64, 3, 0);

        // Reset during BACKOFF
        setup(4'b0001, 20, 39, 1, 1000, -1, 0, 1000, 1'b0);
        pulse_start();
        n = 0;
        while (!(move && !dir) && n < BOUND) begin
            @(negedge fab_clk);
            n++;
        end
        check("backoff_reached", int'(move && !dir), 1);
        reset_n = 1'b0;
        @(negedge fab_clk);
        check("abort_outputs",
              int'({move, dir, load, slip, rx_data_out, data_valid, train_done, train_err,
                    eye_start, eye_end, center_tap}), 0);
        b_sum = inc_cnt + dec_cnt + slip_total + load_cnt;
        repeat (3) @(negedge fab_clk);
        reset_n = 1'b1;
        repeat (30) @(negedge fab_clk);
        check("abort_no_pulses", inc_cnt + dec_cnt + slip_total + load_cnt, b_sum);

        run("retrain_30_45", 4'b0001, 30, 45, 2, 1000, -1, 0, 1000, 1'b0,
            1'b1, 30, 45, 37, 46, 9, 2);

        check("pulse_rules", pulse_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
